// File: rtl/mux_arb_n.sv
// N-channel multiplexer with direct-select or round-robin arbitration and a registered output stage.
// Optional 16-bit saturating stall counter when MUX_ARB_N_STALL_CNT_EN is defined.
module mux_arb_n #(
    parameter int bw_in  = 4,
    parameter int ch_num = 4,
    localparam int SW    = (ch_num > 2) ? $clog2(ch_num) : 1
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    Mode,
    input  logic [SW-1:0]           Select,
    input  logic [ch_num*bw_in-1:0] IN,
    input  logic [ch_num-1:0]       IN_Valid,
    output logic [ch_num-1:0]       IN_Ready,
    output logic [bw_in-1:0]        OUT,
    output logic                    OUT_Valid,
    input  logic                    OUT_Ready,
    output logic [SW-1:0]           OUT_Ch
`ifdef MUX_ARB_N_STALL_CNT_EN
    ,
    output logic [15:0]             Stall_Cnt
`endif
);

    logic [bw_in-1:0]  out_q,       out_d;
    logic              out_valid_q, out_valid_d;
    logic [SW-1:0]     out_ch_q,    out_ch_d;
    logic [SW-1:0]     ptr_q,       ptr_d;

    logic              ld;
    logic              rr_found;
    logic [SW-1:0]     rr_grant;
    logic [ch_num-1:0] in_ready_c;
    logic              xfer;
    logic [SW-1:0]     xfer_ch;
    logic [bw_in-1:0]  xfer_data;

    assign ld = !out_valid_q || OUT_Ready;

    // Rotating search starting just after the last granted channel, ending on it.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int i = 1; i <= ch_num; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % ch_num;
            if (!rr_found && IN_Valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = SW'(idx);
            end
        end
    end

    // An out-of-range Select matches no channel, so nothing is offered.
    always_comb begin
        in_ready_c = '0;
        for (int k = 0; k < ch_num; k++) begin
            if (Mode) begin
                in_ready_c[k] = ld && rr_found && (rr_grant == SW'(k));
            end else begin
                in_ready_c[k] = ld && (Select == SW'(k));
            end
        end
    end

    assign IN_Ready = in_ready_c;
    assign xfer     = |(IN_Valid & in_ready_c);
    assign xfer_ch  = Mode ? rr_grant : Select;

    always_comb begin
        xfer_data = '0;
        for (int k = 0; k < ch_num; k++) begin
            if (xfer_ch == SW'(k)) begin
                xfer_data = IN[k*bw_in +: bw_in];
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (ld) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_d    = xfer_data;
                out_ch_d = xfer_ch;
                if (Mode) begin
                    ptr_d = rr_grant;
                end
            end
        end
    end

    // Reset parks the pointer on the last channel so channel 0 wins first.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= SW'(ch_num - 1);
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_Valid = out_valid_q;
    assign OUT_Ch    = out_ch_q;

`ifdef MUX_ARB_N_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !OUT_Ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Randomized bench for mux_arb_n (ch_num=4, bw_in=8) against a transaction-level reference model.
module tb_mux_arb_n;
    localparam int BW = 8;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            Clock = 1'b0;
    logic            Reset_n;
    logic            Mode;
    logic [SW-1:0]   Select;
    logic [CH*BW-1:0] IN;
    logic [CH-1:0]   IN_Valid;
    logic [CH-1:0]   IN_Ready;
    logic [BW-1:0]   OUT;
    logic            OUT_Valid;
    logic            OUT_Ready;
    logic [SW-1:0]   OUT_Ch;
`ifdef MUX_ARB_N_STALL_CNT_EN
    logic [15:0]     Stall_Cnt;
`endif

    always #5 Clock = ~Clock;

    mux_arb_n #(.bw_in(BW), .ch_num(CH)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Mode      (Mode),
        .Select    (Select),
        .IN        (IN),
        .IN_Valid  (IN_Valid),
        .IN_Ready  (IN_Ready),
        .OUT       (OUT),
        .OUT_Valid (OUT_Valid),
        .OUT_Ready (OUT_Ready),
        .OUT_Ch    (OUT_Ch)
`ifdef MUX_ARB_N_STALL_CNT_EN
        ,
        .Stall_Cnt (Stall_Cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: the word held downstream and the last RR winner.
    logic [BW-1:0] m_out;
    logic          m_vld;
    int            m_ch;
    int            m_ptr;
    int            m_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out   = '0;
        m_vld   = 1'b0;
        m_ch    = 0;
        m_ptr   = CH - 1;
        m_stall = 0;
    endtask

    function automatic logic [CH-1:0] exp_ready(input logic mode, input logic [SW-1:0] sel,
                                                input logic [CH-1:0] vld, input logic ordy);
        if (m_vld && !ordy) return '0;
        if (!mode) return CH'(1) << sel;
        for (int off = 1; off <= CH; off++) begin
            int k;
            k = (m_ptr + off) % CH;
            if (vld[k]) return CH'(1) << k;
        end
        return '0;
    endfunction

    task automatic check_outputs();
        chk("out", 32'(OUT), 32'(m_out));
        chk("out_valid", 32'(OUT_Valid), 32'(m_vld));
        chk("out_ch", 32'(OUT_Ch), 32'(m_ch));
`ifdef MUX_ARB_N_STALL_CNT_EN
        chk("stall_cnt", 32'(Stall_Cnt), 32'(m_stall));
`endif
    endtask

    // One clock cycle: drive, check combinational ready, advance model, check registers.
    task automatic cyc(input logic mode, input logic [SW-1:0] sel, input logic [CH-1:0] vld,
                       input logic [CH*BW-1:0] data, input logic ordy);
        logic [CH-1:0] er;
        Mode      = mode;
        Select    = sel;
        IN_Valid  = vld;
        IN        = data;
        OUT_Ready = ordy;
        #1;
        er = exp_ready(mode, sel, vld, ordy);
        chk("in_ready", 32'(IN_Ready), 32'(er));
        if (m_vld && !ordy && m_stall < 65535) m_stall++;
        if (!m_vld || ordy) begin
            m_vld = 1'b0;
            for (int k = 0; k < CH; k++) begin
                if (er[k] && vld[k]) begin
                    m_vld = 1'b1;
                    m_out = data[k*BW +: BW];
                    m_ch  = k;
                    if (mode) m_ptr = k;
                end
            end
        end
        @(posedge Clock);
        #1;
        check_outputs();
    endtask

    logic [CH*BW-1:0] rnd_data;
    int stall_before;

    initial begin
        Reset_n   = 1'b0;
        Mode      = 1'b0;
        Select    = '0;
        IN        = '0;
        IN_Valid  = '0;
        OUT_Ready = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_outputs();
        @(negedge Clock);
        Reset_n = 1'b1;

        // Round-robin fairness from reset: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'd0, 4'b1111, 32'hD3C2B1A0 + 32'(i), 1'b1);
            chk("rr_seq", 32'(OUT_Ch), 32'(i % CH));
            chk("rr_seq_vld", 32'(OUT_Valid), 32'd1);
        end

        // Direct select of channel 2
        cyc(1'b0, 2'd2, 4'b1111, 32'h44A52211, 1'b1);
        chk("direct_out", 32'(OUT), 32'hA5);
        chk("direct_ch", 32'(OUT_Ch), 32'd2);

        // Sparse wrap: force ptr=2, then only ch0/ch1 valid
        cyc(1'b1, 2'd0, 4'b0100, 32'h0F0E0D0C, 1'b1);
        cyc(1'b1, 2'd0, 4'b0011, 32'h0F0E0D0C, 1'b1);
        chk("wrap_a", 32'(OUT_Ch), 32'd0);
        cyc(1'b1, 2'd0, 4'b0011, 32'h0F0E0D0C, 1'b1);
        chk("wrap_b", 32'(OUT_Ch), 32'd1);
        cyc(1'b1, 2'd0, 4'b0011, 32'h0F0E0D0C, 1'b1);
        chk("wrap_c", 32'(OUT_Ch), 32'd0);

        // Backpressure for 5 cycles, then pop+load in one cycle
        stall_before = m_stall;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'd0, 4'b1111, 32'h55667788, 1'b0);
            chk("bp_ready", 32'(IN_Ready), 32'd0);
            chk("bp_hold", 32'(OUT), 32'h0C);
        end
        chk("bp_stall_delta", 32'(m_stall - stall_before), 32'd5);
        cyc(1'b1, 2'd0, 4'b1111, 32'h55667788, 1'b1);
        chk("bp_release_vld", 32'(OUT_Valid), 32'd1);
        chk("bp_release_ch", 32'(OUT_Ch), 32'd1);

        // Mode switch: RR grant ch1, two direct ch3 transfers, back to RR -> ch2
        cyc(1'b1, 2'd0, 4'b0010, 32'h01020304, 1'b1);
        cyc(1'b0, 2'd3, 4'b1111, 32'h01020304, 1'b1);
        cyc(1'b0, 2'd3, 4'b1111, 32'h01020304, 1'b1);
        chk("ms_direct_ch", 32'(OUT_Ch), 32'd3);
        cyc(1'b1, 2'd0, 4'b1111, 32'h01020304, 1'b1);
        chk("ms_rr_ch", 32'(OUT_Ch), 32'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_data = {$urandom, $urandom} [CH*BW-1:0];
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                rnd_data, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-stream, away from any clock edge
        cyc(1'b1, 2'd0, 4'b1111, 32'hCAFEBABE, 1'b1);
        chk("pre_rst_vld", 32'(OUT_Valid), 32'd1);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge Clock);
        Reset_n = 1'b1;
        cyc(1'b1, 2'd0, 4'b1111, 32'h9988_7766, 1'b1);
        chk("post_rst_ch0", 32'(OUT_Ch), 32'd0);
        chk("post_rst_out", 32'(OUT), 32'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter bw_in, default 4: data bit width per channel, >=1.
REQ-002 Parameter ch_num, default 4: input channel count, >=2; sw = max(1, clog2(ch_num)).
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Mode  input  1  0 = direct select, 1 = round-robin arbitration.
REQ-006 Select  input  sw  channel index used in direct mode; ignored in round-robin mode.
REQ-007 IN  input  ch_num*bw_in  flattened channel data; channel k at bits [k*bw_in +: bw_in].
REQ-008 IN_Valid  input  ch_num  per-channel data-valid.
REQ-009 IN_Ready  output  ch_num  per-channel accept, combinational, at most one bit high.
REQ-010 OUT  output  bw_in  registered output data.
REQ-011 OUT_Valid  output  1  registered output-valid.
REQ-012 OUT_Ready  input  1  downstream accept.
REQ-013 OUT_Ch  output  sw  registered index of the channel that supplied OUT.

Function
REQ-014 Load enable: ld = !OUT_Valid || OUT_Ready; the output register updates only when ld=1.
REQ-015 Transfer on channel k: IN_Valid[k] && IN_Ready[k]; transfer at edge n gives OUT=IN[k], OUT_Ch=k, OUT_Valid=1 after edge n (1-cycle latency).
REQ-016 If ld=1 and no transfer occurs, OUT_Valid shall clear to 0; OUT and OUT_Ch shall hold.
REQ-017 If ld=0, OUT, OUT_Ch and OUT_Valid shall hold, and all IN_Ready bits shall be 0.
REQ-018 Direct mode: IN_Ready[Select] = ld; all other bits 0. Select >= ch_num yields IN_Ready=0.
REQ-019 Round-robin mode: grant = first k with IN_Valid[k]=1, searching ptr+1, ptr+2, ... with wrap from ch_num-1 to 0, ending at ptr.
REQ-020 Round-robin mode: IN_Ready[grant] = ld; IN_Ready=0 when no IN_Valid bit is set.
REQ-021 Pointer ptr (sw bits) shall update to the granted index on each round-robin transfer only.
REQ-022 ptr shall be unchanged by direct-mode transfers and by Mode changes. A Mode change shall take effect combinationally, in the same cycle.
REQ-023 Full throughput: with OUT_Ready held at 1 and inputs continuously valid, one transfer per cycle.
REQ-024 Simultaneous downstream pop and upstream load in the same cycle shall replace OUT with no bubble.

Reset
REQ-025 Reset_n=0 shall immediately clear OUT=0, OUT_Valid=0, OUT_Ch=0, and set ptr=ch_num-1, so that channel 0 has first priority.
REQ-026 Reset asserted mid-transfer shall discard the held word. The first edge after deassertion behaves as from the empty state.

Configuration
REQ-027 Macro MUX_ARB_N_STALL_CNT_EN: when defined, adds output Stall_Cnt (16 bits), a registered counter that increments each cycle OUT_Valid && !OUT_Ready is true.
REQ-028 Stall_Cnt shall saturate at 16'hFFFF and reset to 0.
REQ-029 Without the macro, the Stall_Cnt port and its logic shall be absent; all other behaviour is identical.

Verification (ch_num=4, bw_in=8)
REQ-030 Reset: Reset_n=0 mid-stream -> OUT=0, OUT_Valid=0, OUT_Ch=0 without a clock edge; first RR grant after release goes to ch0.
REQ-031 Direct: Mode=0, Select=2, IN_Valid=4'b1111, IN ch2=8'hA5, OUT_Ready=1 -> next cycle OUT=8'hA5, OUT_Ch=2; IN_Ready=4'b0100.
REQ-032 Round-robin fairness: Mode=1, IN_Valid=4'b1111 held, OUT_Ready=1 -> OUT_Ch sequence 0,1,2,3,0; one transfer per cycle.
REQ-033 Sparse wrap: Mode=1, ptr=2, IN_Valid=4'b0011 -> grant ch0, then ch1, then ch0.
REQ-034 Backpressure: OUT_Valid=1, OUT_Ready=0 for 5 cycles -> IN_Ready=0 and OUT stable; with macro, Stall_Cnt=5; release -> pop and load in the same cycle.
REQ-035 Mode switch: after RR grant ch1, set Mode=0, Select=3 for 2 transfers, return to Mode=1 with all inputs valid -> next grant ch2.
